alu_op_sequencer: RTL and testbench

Sequential stage directly upstream of the 3-to-8 decoder in the ALU datapath. It accepts ALU operation requests over a valid/ready handshake, queues them in a small FIFO, and presents each 3-bit operation code on select lines A/B/C for a per-request number of cycles. It also flags the active operation and its final cycle, so downstream logic gates the decoder's one-hot output and knows when each result is complete.

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/alu_op_sequencer_if.sv | 33 +++
 rtl/alu_op_fifo.sv | 63 ++++++
 rtl/alu_op_sequencer.sv | 112 +++++++++++
 tb/tb_alu_op_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer.
//   OP_W    : width of an ALU operation code (maps onto decoder selects C/B/A)
//   state_e : sequencer FSM state
//   op_t    : operation code type
package alu_seq_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [OP_W-1:0] op_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request handshake and decoder-facing outputs of the ALU operation sequencer.
//   master : request source / downstream consumer (drives REQ_*, reads outputs)
//   slave  : the sequencer itself
interface alu_op_sequencer_if #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CYC_W = 3
);
    import alu_seq_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             REQ_VALID;
    logic             REQ_READY;
    op_t              REQ_OP;
    logic [CYC_W-1:0] REQ_CYC;
    logic             A;
    logic             B;
    logic             C;
    logic             OP_ACTIVE;
    logic             OP_DONE;
    logic [CNT_W-1:0] Q_COUNT;

    modport master (
        output REQ_VALID, REQ_OP, REQ_CYC,
        input  REQ_READY, A, B, C, OP_ACTIVE, OP_DONE, Q_COUNT
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_CYC,
        output REQ_READY, A, B, C, OP_ACTIVE, OP_DONE, Q_COUNT
    );

endinterface

// File: rtl/alu_op_fifo.sv
// Synchronous circular-buffer FIFO holding queued sequencer requests.
//   clk_i            : clock
//   clear_i          : synchronous flush (pointers and count to zero)
//   push_i / wdata_i : write one entry (caller guarantees !full_o)
//   pop_i  / rdata_o : head entry, advanced on pop (caller guarantees !empty_o)
//   full_o, empty_o, count_o : occupancy status
module alu_op_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned W     = 6,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     wdata_i,
    output logic [W-1:0]     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage: no reset, validity is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU operation requests and holds each op code on the decoder
// select lines C/B/A for REQ_CYC+1 cycles, back-to-back when queued.
//   CLK, RST (sync, active-high), ABORT (sync flush of current op and queue)
//   bus : request handshake in, A/B/C/OP_ACTIVE/OP_DONE/Q_COUNT/REQ_READY out
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CYC_W = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ABORT,
    alu_op_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        op_t              op;
        logic [CYC_W-1:0] cyc;
    } entry_t;

    localparam int unsigned ENT_W = $bits(entry_t);

    state_e           state_q, state_d;
    op_t              op_q, op_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    entry_t           wentry;
    entry_t           head;

    // Ready depends on registered occupancy only, never on a same-cycle pop.
    assign bus.REQ_READY = !fifo_full;
    assign push          = bus.REQ_VALID && !fifo_full && !ABORT && !RST;
    assign wentry        = '{op: bus.REQ_OP, cyc: bus.REQ_CYC};

    alu_op_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk_i   (CLK),
        .clear_i (RST || ABORT),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state: load from queue head when idle or on the final hold cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        if (ABORT) begin
            state_d = IDLE;
            op_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = RUN;
                        op_d    = head.op;
                        cnt_d   = head.cyc;
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CYC_W'(1);
                    end else if (!fifo_empty) begin
                        pop   = 1'b1;
                        op_d  = head.op;
                        cnt_d = head.cyc;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode from registers only.
    assign bus.OP_ACTIVE         = (state_q == RUN);
    assign bus.OP_DONE           = (state_q == RUN) && (cnt_q == '0);
    assign {bus.C, bus.B, bus.A} = (state_q == RUN) ? op_q : '0;
    assign bus.Q_COUNT           = fifo_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CYC_W = 3;

    logic CLK = 1'b0;
    logic RST;
    logic ABORT;

    always #5 CLK = ~CLK;

    alu_op_sequencer_if #(.DEPTH(DEPTH), .CYC_W(CYC_W)) bus ();

    alu_op_sequencer #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .ABORT (ABORT),
        .bus   (bus)
    );

    // Reference model: a list of waiting requests plus the op currently
    // shown and how many display cycles it still has (including this one).
    typedef struct {
        int op;
        int cyc;
    } ent_t;

    ent_t mq[$];
    bit   m_act  = 1'b0;
    int   m_op   = 0;
    int   m_left = 0;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   seen[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic void model_edge(bit v, int op, int cyc, bit ab, bit rs);
        bit   acc;
        ent_t e;
        acc = v && (mq.size() != DEPTH);
        if (rs || ab) begin
            mq.delete();
            m_act  = 1'b0;
            m_left = 0;
            m_op   = 0;
            return;
        end
        if (m_act && m_left > 1) begin
            m_left--;
        end else if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_act  = 1'b1;
            m_op   = e.op;
            m_left = e.cyc + 1;
        end else begin
            m_act = 1'b0;
        end
        if (acc) mq.push_back('{op, cyc});
    endfunction

    task automatic compare_all();
        check("ready",  32'(bus.REQ_READY), 32'(mq.size() != DEPTH));
        check("active", 32'(bus.OP_ACTIVE), 32'(m_act));
        check("done",   32'(bus.OP_DONE),   32'(m_act && m_left == 1));
        check("abc",    32'({bus.C, bus.B, bus.A}), m_act ? 32'(m_op) : 32'd0);
        check("qcount", 32'(bus.Q_COUNT),   32'(mq.size()));
    endtask

    // One clock: apply inputs, advance model at the edge, compare just after.
    task automatic step(input bit v, input int op, input int cyc, input bit ab, input bit rs);
        bus.REQ_VALID = v;
        bus.REQ_OP    = 3'(op);
        bus.REQ_CYC   = CYC_W'(cyc);
        ABORT         = ab;
        RST           = rs;
        @(posedge CLK);
        model_edge(v, op, cyc, ab, rs);
        #1;
        compare_all();
        if (bus.OP_ACTIVE === 1'b1) seen.push_back(int'({bus.C, bus.B, bus.A}));
    endtask

    // Hold REQ_VALID with the next item until accepted, then drain.
    task automatic drive_list(input int ops[$], input int cycs[$]);
        int  guard;
        bit  rdy;
        guard = 0;
        while ((ops.size() > 0 || m_act || mq.size() > 0) && guard < 200) begin
            rdy = (mq.size() != DEPTH);
            if (ops.size() > 0) begin
                step(1'b1, ops[0], cycs[0], 1'b0, 1'b0);
                if (rdy) begin
                    void'(ops.pop_front());
                    void'(cycs.pop_front());
                end
            end else begin
                step(1'b0, 0, 0, 1'b0, 1'b0);
            end
            guard++;
        end
        if (guard >= 200) begin
            n_chk++;
            $error("FAIL drain_timeout observed=busy expected=idle");
        end
    endtask

    initial begin
        int exp_seq[$];
        int ops[$];
        int cycs[$];

        bus.REQ_VALID = 1'b0;
        bus.REQ_OP    = '0;
        bus.REQ_CYC   = '0;
        ABORT         = 1'b0;
        RST           = 1'b1;

        // Reset held with a request offered: nothing may be queued.
        repeat (3) step(1'b1, 5, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        check("rst_active", 32'(bus.OP_ACTIVE), 32'd0);
        check("rst_done",   32'(bus.OP_DONE),   32'd0);
        check("rst_abc",    32'({bus.C, bus.B, bus.A}), 32'd0);
        check("rst_qcount", 32'(bus.Q_COUNT),   32'd0);
        check("rst_ready",  32'(bus.REQ_READY), 32'd1);

        // Single op=6 cyc=2: three cycles of 110, done in the third only.
        step(1'b1, 6, 2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 0, 1'b0, 1'b0);
            check($sformatf("single_act%0d", i),  32'(bus.OP_ACTIVE), 32'(i < 3));
            check($sformatf("single_done%0d", i), 32'(bus.OP_DONE),   32'(i == 2));
            check($sformatf("single_abc%0d", i),  32'({bus.C, bus.B, bus.A}), (i < 3) ? 32'd6 : 32'd0);
        end

        // Back-to-back: 011 x1, 100 x2, 111 x1 with no gap.
        seen.delete();
        step(1'b1, 3, 0, 1'b0, 1'b0);
        step(1'b1, 4, 1, 1'b0, 1'b0);
        step(1'b1, 7, 0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 0, 0, 1'b0, 1'b0);
        exp_seq = '{3, 4, 4, 7};
        check("b2b_len", 32'(seen.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < seen.size(); i++)
            check($sformatf("b2b_seq%0d", i), 32'(seen[i]), 32'(exp_seq[i]));

        // Long op fills the queue; later pushes wait for the done edge.
        ops  = '{1, 2, 3, 4, 5};
        cycs = '{5, 0, 0, 1, 0};
        drive_list(ops, cycs);

        // Abort in the done cycle with two queued and a push pending.
        step(1'b1, 1, 1, 1'b0, 1'b0);
        step(1'b1, 2, 3, 1'b0, 1'b0);
        step(1'b1, 3, 0, 1'b0, 1'b0);
        check("abort_pre_done",   32'(bus.OP_DONE), 32'd1);
        check("abort_pre_qcount", 32'(bus.Q_COUNT), 32'd2);
        step(1'b1, 5, 0, 1'b1, 1'b0);
        check("abort_active", 32'(bus.OP_ACTIVE), 32'd0);
        check("abort_done",   32'(bus.OP_DONE),   32'd0);
        check("abort_qcount", 32'(bus.Q_COUNT),   32'd0);
        repeat (3) step(1'b0, 0, 0, 1'b0, 1'b0);
        check("abort_dropped", 32'(bus.OP_ACTIVE), 32'd0);

        // Pointer wrap: ten cyc=0 ops must come out in push order.
        seen.delete();
        ops  = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        cycs = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_seq = ops;
        drive_list(ops, cycs);
        check("wrap_len", 32'(seen.size()), 32'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < seen.size(); i++)
            check($sformatf("wrap_seq%0d", i), 32'(seen[i]), 32'(exp_seq[i]));

        // Randomized traffic with occasional abort and reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 5) == 0) ? 7 : int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 99) == 0));
        end
        repeat (10) step(1'b0, 0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
